// File: rtl/fir_coef_loader.sv
// Writer side of the 7-tap FIR coefficient interface: byte-serial frame load, atomic commit, optional zero flush.
// Optional flush of the FIR pipeline after commit is enabled by defining FIR_LOADER_FLUSH_EN.
module fir_coef_loader #(
  parameter logic [7:0] HDR    = 8'hA5,
  parameter logic [7:0] B0_RST = 8'h40
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_abort,
  input  logic [7:0]  x_in,
  input  logic        x_in_valid,
  output logic        x_in_ready,
  output logic [7:0]  x_out,
  output logic [55:0] b_out,
  output logic        cfg_busy,
  output logic        cfg_err,
  output logic [3:0]  coef_ver
);

  localparam int unsigned NTAPS = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned IDXW  = 3;
  localparam int unsigned BW    = NTAPS * DW;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [BW-1:0]      shadow_q, shadow_d;
  logic [BW-1:0]      b_q, b_d;
  logic [3:0]         ver_q, ver_d;
  logic               err_q, err_d;
  logic [DW-1:0]      xout_q, xout_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               cfg_acc;
`ifdef FIR_LOADER_FLUSH_EN
  logic [IDXW-1:0]    fcnt_q, fcnt_d;
  logic               xready_q, xready_d;
`endif

  // Handshake/status outputs are registered from the next state so they track the state exactly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    b_d      = b_q;
    ver_d    = ver_q;
    err_d    = err_q;
    cfg_acc  = cfg_valid && cfg_ready_q;
`ifdef FIR_LOADER_FLUSH_EN
    fcnt_d   = fcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_acc) begin
          if (cfg_data == HDR) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // Abort wins over a byte presented in the same cycle; that byte is dropped.
        if (cfg_abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (cfg_acc) begin
          for (int unsigned i = 0; i < NTAPS; i++) begin
            if (idx_q == IDXW'(i)) shadow_d[i*DW +: DW] = cfg_data;
          end
          if (idx_q == IDXW'(NTAPS - 1)) begin
            state_d = ST_COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      ST_COMMIT: begin
        b_d   = shadow_q;
        ver_d = ver_q + 4'd1;
`ifdef FIR_LOADER_FLUSH_EN
        state_d = ST_FLUSH;
        fcnt_d  = IDXW'(NTAPS - 1);
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef FIR_LOADER_FLUSH_EN
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - IDXW'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
`ifdef FIR_LOADER_FLUSH_EN
    xready_d    = (state_d != ST_FLUSH);
`endif
    xout_d      = (x_in_valid && x_in_ready) ? x_in : '0;
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      b_q         <= {{(BW-DW){1'b0}}, B0_RST};
      ver_q       <= '0;
      err_q       <= 1'b0;
      xout_q      <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FIR_LOADER_FLUSH_EN
      fcnt_q      <= '0;
      xready_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      b_q         <= b_d;
      ver_q       <= ver_d;
      err_q       <= err_d;
      xout_q      <= xout_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
`ifdef FIR_LOADER_FLUSH_EN
      fcnt_q      <= fcnt_d;
      xready_q    <= xready_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_err   = err_q;
  assign coef_ver  = ver_q;
  assign b_out     = b_q;
  assign x_out     = xout_q;
`ifdef FIR_LOADER_FLUSH_EN
  assign x_in_ready = xready_q;
`else
  assign x_in_ready = 1'b1;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized self-checking bench for fir_coef_loader against a frame-level reference model.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        cfg_valid, cfg_ready, cfg_abort;
  logic [7:0]  cfg_data;
  logic [7:0]  x_in, x_out;
  logic        x_in_valid, x_in_ready;
  logic [55:0] b_out;
  logic        cfg_busy, cfg_err;
  logic [3:0]  coef_ver;

  int n_chk = 0;
  int n_err = 0;
  int sample_mode = 0;

  fir_coef_loader dut (
    .clk(clk), .Rst_n(Rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_abort(cfg_abort),
    .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready), .x_out(x_out),
    .b_out(b_out), .cfg_busy(cfg_busy), .cfg_err(cfg_err), .coef_ver(coef_ver)
  );

  always #5 clk = ~clk;

`ifdef FIR_LOADER_FLUSH_EN
  localparam int FLUSH_LEN = 7;
`else
  localparam int FLUSH_LEN = 0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame progress, pending commit and remaining flush cycles.
  bit         m_live = 0;
  bit         m_frame, m_pend, m_err;
  int         m_n, m_flush;
  logic [7:0] m_shadow [7];
  logic [7:0] m_taps [7];
  logic [3:0] m_ver;
  logic [7:0] m_xout;

  function automatic logic [55:0] m_bvec();
    logic [55:0] v;
    for (int i = 0; i < 7; i++) v[i*8 +: 8] = m_taps[i];
    return v;
  endfunction

  task automatic model_edge();
    if (!Rst_n) begin
      m_live = 1; m_frame = 0; m_pend = 0; m_err = 0; m_n = 0; m_flush = 0;
      m_ver = 0; m_xout = 0;
      for (int i = 0; i < 7; i++) begin m_shadow[i] = 0; m_taps[i] = 0; end
      m_taps[0] = 8'h40;
      return;
    end
    if (!m_live) return;
    m_xout = (x_in_valid && m_flush == 0) ? x_in : 8'h00;
    if (m_pend) begin
      for (int i = 0; i < 7; i++) m_taps[i] = m_shadow[i];
      m_ver   = m_ver + 4'd1;
      m_pend  = 0;
      m_flush = FLUSH_LEN;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (!m_frame) begin
      if (cfg_valid) begin
        if (cfg_data == 8'hA5) begin m_frame = 1; m_n = 0; m_err = 0; end
        else m_err = 1;
      end
    end else if (cfg_abort) begin
      m_frame = 0; m_n = 0;
    end else if (cfg_valid) begin
      m_shadow[m_n] = cfg_data;
      m_n++;
      if (m_n == 7) begin m_frame = 0; m_n = 0; m_pend = 1; end
    end
  endtask

  // Every cycle: advance the model on the edge, compare all outputs just after it.
  always @(posedge clk) begin
    model_edge();
    #1;
    if (m_live) begin
      check("b_out", 64'(b_out), 64'(m_bvec()));
      check("coef_ver", 64'(coef_ver), 64'(m_ver));
      check("cfg_err", 64'(cfg_err), 64'(m_err));
      check("cfg_ready", 64'(cfg_ready), 64'(!m_pend && m_flush == 0));
      check("cfg_busy", 64'(cfg_busy), 64'(m_frame || m_pend || m_flush > 0));
      check("x_in_ready", 64'(x_in_ready), 64'(m_flush == 0));
      check("x_out", 64'(x_out), 64'(m_xout));
    end
  end

  // Sample source: random, constant 08, or idle.
  initial begin
    x_in = 0; x_in_valid = 0;
    forever begin
      @(posedge clk); #1;
      case (sample_mode)
        1:       begin x_in = 8'h08; x_in_valid = 1'b1; end
        2:       begin x_in = 8'($urandom); x_in_valid = 1'b0; end
        default: begin x_in = 8'($urandom); x_in_valid = ($urandom_range(0, 3) != 0); end
      endcase
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done = 0;
    for (int g = 0; g < gap; g++) begin cfg_valid = 0; step(); end
    cfg_valid = 1; cfg_data = b;
    for (int n = 0; n < 50 && !done; n++) begin done = cfg_ready; step(); end
    cfg_valid = 0;
    if (!done) check("hs_timeout", 64'(done), 64'(1));
  endtask

  task automatic send_frame(input logic [55:0] taps, input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    for (int i = 0; i < 7; i++) send_byte(taps[i*8 +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && cfg_busy; k++) step();
    check("idle_timeout", 64'(cfg_busy), 64'(0));
  endtask

  initial begin
    logic [55:0] taps;
    logic [3:0]  ver0;
    Rst_n = 0; cfg_valid = 0; cfg_abort = 0; cfg_data = 0;
    step(2);
    Rst_n = 1;
    check("rst_b_out", 64'(b_out), 64'h40);
    check("rst_x_out", 64'(x_out), 64'h0);
    check("rst_ver", 64'(coef_ver), 64'h0);
    check("rst_err", 64'(cfg_err), 64'h0);
    check("rst_ready", 64'(cfg_ready), 64'h1);

    // Back-to-back frame 01..07.
    send_frame(56'h07060504030201, 0);
    step();
    check("frame_b_out", 64'(b_out), 64'h07060504030201);
    check("frame_ver", 64'(coef_ver), 64'h1);
    check("flush_ready0", 64'(x_in_ready), 64'(FLUSH_LEN == 0));
    step(7);
    check("flush_ready1", 64'(x_in_ready), 64'h1);
    wait_idle();

    // Partial frame then abort.
    send_byte(8'hA5, 0); send_byte(8'h10, 1); send_byte(8'h20, 0); send_byte(8'h30, 2);
    cfg_abort = 1; step(); cfg_abort = 0; step(2);
    check("abort_b_out", 64'(b_out), 64'h07060504030201);
    check("abort_ver", 64'(coef_ver), 64'h1);
    check("abort_busy", 64'(cfg_busy), 64'h0);
    send_frame(56'h77665544332211, 2);
    step();
    check("after_abort_b", 64'(b_out), 64'h77665544332211);
    check("after_abort_ver", 64'(coef_ver), 64'h2);
    wait_idle();

    // Abort and byte in the same LOAD cycle.
    send_byte(8'hA5, 0);
    cfg_valid = 1; cfg_data = 8'h55; cfg_abort = 1; step();
    cfg_valid = 0; cfg_abort = 0; step();
    check("abort_win_busy", 64'(cfg_busy), 64'h0);

    // Non-header byte in IDLE, then header.
    send_byte(8'h3C, 0); step();
    check("err_set", 64'(cfg_err), 64'h1);
    check("err_idle", 64'(cfg_busy), 64'h0);
    send_byte(8'hA5, 0);
    check("err_clr", 64'(cfg_err), 64'h0);
    check("hdr_load", 64'(cfg_busy), 64'h1);
    cfg_abort = 1; step(); cfg_abort = 0;

    // Constant sample stream then idle source.
    sample_mode = 1; step(4);
    check("x_08", 64'(x_out), 64'h08);
    sample_mode = 2; step(2);
    check("x_zero", 64'(x_out), 64'h00);
    sample_mode = 0;

    // Sixteen frames with gaps: version wraps back.
    ver0 = coef_ver;
    for (int f = 0; f < 16; f++) begin
      taps = {$urandom, $urandom};
      send_frame(taps, 3);
      step();
      check("rand_frame_b", 64'(b_out), 64'(taps));
      wait_idle();
    end
    check("ver_wrap", 64'(coef_ver), 64'(ver0));

    // Reset during the commit cycle discards the frame.
    send_frame(56'h0102030405060A, 0);
    Rst_n = 0; step(); Rst_n = 1;
    check("rst_commit_b", 64'(b_out), 64'h40);
    check("rst_commit_ver", 64'(coef_ver), 64'h0);

    // Random traffic with aborts, headers and occasional resets.
    for (int c = 0; c < 600; c++) begin
      cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_data  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
      cfg_abort = ($urandom_range(0, 15) == 0);
      Rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end
    cfg_valid = 0; cfg_abort = 0; Rst_n = 1;
    step(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
